// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction-fetch stage placed directly after the PC register. It samples the
// PC, runs a req/ack handshake with instruction memory and drives the IF/ID
// pipeline register. An ID-stage stall is absorbed by a one-entry park buffer.
// A branch flush squashes the IF/ID instruction and any in-flight request.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous, active-high reset
//   pc_i         PC register value, sampled in ISSUE only
//   pc_write_o   PC register write enable (top level ORs it with flush_i)
//   stall_i      ID-stage stall: hold the IF/ID outputs
//   flush_i      taken branch/jump: squash fetched and in-flight instruction
//   imem_req_o   instruction memory request
//   imem_addr_o  word-aligned request address
//   imem_ack_i   memory response valid (data valid in the same cycle)
//   imem_data_i  fetched instruction
//   inst_o       IF/ID instruction
//   pc_o         address of inst_o
//   pc_plus4_o   pc_o + 4
//   valid_o      inst_o is a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_write_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_data_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              valid_o
);

  typedef enum logic [1:0] {
    ISSUE, // sample the PC, no request
    FETCH, // request outstanding, waiting for ack
    HOLD,  // response parked while ID stalls
    DRAIN  // flushed request still outstanding; its data will be dropped
  } state_t;

  state_t state_q, state_d;

  logic [INST_W-1:0] buf_inst;
  logic [ADDR_W-1:0] buf_addr;

  logic              accept;   // new instruction enters IF/ID this edge
  logic              park;     // response captured into the park buffer
  logic [INST_W-1:0] new_inst;
  logic [ADDR_W-1:0] new_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] aligned_pc;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    park    = 1'b0;
    unique case (state_q)
      ISSUE: state_d = FETCH;
      FETCH: begin
        // Flush outranks ack: an acked-but-flushed response is simply dropped.
        if (flush_i)         state_d = imem_ack_i ? ISSUE : DRAIN;
        else if (imem_ack_i) begin
          if (!stall_i) accept = 1'b1;
          else begin
            park    = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush_i)       state_d = ISSUE;
        else if (!stall_i) begin
          accept  = 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: if (imem_ack_i) state_d = ISSUE;
      default: state_d = ISSUE;
    endcase
  end

  // An accept comes either from memory (FETCH) or from the park buffer (HOLD).
  assign new_inst   = (state_q == HOLD) ? buf_inst : imem_data_i;
  assign new_addr   = (state_q == HOLD) ? buf_addr : imem_addr_o;
  assign next_addr  = new_addr + ADDR_W'(4);
  assign aligned_pc = pc_i & ~ADDR_W'(3);

  assign imem_req_o = (state_q == FETCH) || (state_q == DRAIN);
  assign pc_write_o = accept;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ISSUE;
    else       state_q <= state_d;
  end

  // Request address: loaded from the PC in ISSUE, advanced on accept, and held
  // otherwise so it stays stable while a request (including DRAIN) is pending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 imem_addr_o <= '0;
    else if (state_q == ISSUE) imem_addr_o <= aligned_pc;
    else if (accept)           imem_addr_o <= next_addr;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_inst <= '0;
      buf_addr <= '0;
    end else if (park) begin
      buf_inst <= imem_data_i;
      buf_addr <= imem_addr_o;
    end
  end

  // IF/ID register: flush > stall (hold) > accept > bubble.
  // Bubbles and flushes keep the pc fields of the last real instruction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inst_o     <= NOP_INST;
      pc_o       <= '0;
      pc_plus4_o <= '0;
      valid_o    <= 1'b0;
    end else if (flush_i) begin
      inst_o  <= NOP_INST;
      valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (accept) begin
        inst_o     <= new_inst;
        pc_o       <= new_addr;
        pc_plus4_o <= next_addr;
        valid_o    <= 1'b1;
      end else begin
        inst_o  <= NOP_INST;
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Stimulus process: acts as the PC register's driver and as instruction memory
// (configurable wait states), drives stall/flush, and pushes the expected
// instruction stream (sequential addresses from each reset/flush target) into
// a queue. Monitor process: every cycle classifies what the IF/ID register did
// and, on each newly presented instruction, pops and compares the expectation.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_write_o;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;

  inst_fetch_unit #(.ADDR_W(32), .INST_W(32), .NOP_INST(32'h0000_0000)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pc_i        (pc_i),
    .pc_write_o  (pc_write_o),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_data_i (imem_data_i),
    .inst_o      (inst_o),
    .pc_o        (pc_o),
    .pc_plus4_o  (pc_plus4_o),
    .valid_o     (valid_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          delivered = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pc_reg    = '0;
  logic [31:0] flush_tgt = '0;
  int          mem_wait  = 0;
  int          wcnt      = 0;
  bit          rnd_mode  = 1'b0;

  // Memory contents: a distinct, non-NOP word for every address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic restart_q(input logic [31:0] t);
    exp_q.delete();
    exp_q.push_back(t);
  endtask

  // One cycle: drive memory response and pc_i just after the falling edge,
  // then wait for the next falling edge (the rising edge lies in between).
  task automatic tick();
    logic [31:0] nx;
    #1;
    if (flush_i) restart_q(flush_tgt);
    while (exp_q.size() < 8) begin
      nx = exp_q[$] + 32'd4;
      exp_q.push_back(nx);
    end
    if (imem_req_o) begin
      if (wcnt >= mem_wait) begin
        imem_ack_i  = 1'b1;
        imem_data_i = mem_fn(imem_addr_o);
        wcnt        = 0;
        if (rnd_mode) mem_wait = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      end else begin
        imem_ack_i  = 1'b0;
        imem_data_i = $urandom;
        wcnt++;
      end
    end else begin
      wcnt        = 0;
      imem_ack_i  = rnd_mode ? ($urandom_range(0, 3) == 0) : 1'b0;  // stray acks must be ignored
      imem_data_i = $urandom;
    end
    pc_i = rnd_mode ? {pc_reg[31:2], 2'($urandom_range(0, 3))} : pc_reg;
    @(negedge clk_i);
  endtask

  task automatic do_reset(input logic [31:0] start);
    rst_i      = 1'b1;
    stall_i    = 1'b0;
    flush_i    = 1'b0;
    imem_ack_i = 1'b0;
    pc_reg     = start;
    wcnt       = 0;
    restart_q(start);
    repeat (2) @(negedge clk_i);
    check("reset_valid", valid_o, 1'b0);
    check("reset_inst", inst_o, NOP);
    check("reset_req", imem_req_o, 1'b0);
    check("reset_pc_write", pc_write_o, 1'b0);
    rst_i = 1'b0;
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    bit          have_pre = 1'b0;
    logic        st_p = 0, fl_p = 0, pw_p = 0, req_p = 0, ack_p = 0;
    logic [31:0] addr_p = '0, tgt_p = '0;
    logic [31:0] inst_prev = '0, pc_prev = '0, pc4_prev = '0;
    logic        v_prev = 0;
    logic [31:0] e;
    forever begin
      @(negedge clk_i);
      if (!rst_i && have_pre) begin
        if (fl_p) begin
          check("flush_valid", valid_o, 1'b0);
          check("flush_inst", inst_o, NOP);
          check("flush_pc_kept", pc_o, pc_prev);
          check("flush_pc4_kept", pc_plus4_o, pc4_prev);
          check("flush_pc_write", pw_p, 1'b0);
        end else if (st_p) begin
          check("stall_inst", inst_o, inst_prev);
          check("stall_pc", pc_o, pc_prev);
          check("stall_pc4", pc_plus4_o, pc4_prev);
          check("stall_valid", valid_o, v_prev);
          check("stall_pc_write", pw_p, 1'b0);
        end else if (valid_o) begin
          check("accept_pc_write", pw_p, 1'b1);
          check("scoreboard_nonempty", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            delivered++;
            check("accept_pc", pc_o, e);
            check("accept_inst", inst_o, mem_fn(e));
            check("accept_pc4", pc_plus4_o, e + 32'd4);
          end
        end else begin
          check("bubble_pc_write", pw_p, 1'b0);
          check("bubble_inst", inst_o, NOP);
          check("bubble_pc_kept", pc_o, pc_prev);
        end
        if (req_p && !ack_p) begin
          check("req_held", imem_req_o, 1'b1);
          check("addr_held", imem_addr_o, addr_p);
        end
        check("addr_aligned", {30'd0, imem_addr_o[1:0]}, 32'd0);
        // PC register behaviour: branch target on flush, +4 on pc_write.
        if (fl_p)      pc_reg = tgt_p;
        else if (pw_p) pc_reg = pc_reg + 32'd4;
      end
      inst_prev = inst_o;
      pc_prev   = pc_o;
      pc4_prev  = pc_plus4_o;
      v_prev    = valid_o;
      #2;
      st_p     = stall_i;
      fl_p     = flush_i;
      pw_p     = pc_write_o;
      req_p    = imem_req_o;
      ack_p    = imem_ack_i;
      addr_p   = imem_addr_o;
      tgt_p    = flush_tgt;
      have_pre = !rst_i;
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin : stimulus
    int d0;

    // Zero-wait memory: one instruction per cycle.
    do_reset(32'h0);
    mem_wait = 0;
    tick();
    check("t1_req_cycle1", imem_req_o, 1'b1);
    check("t1_addr_cycle1", imem_addr_o, 32'h0);
    tick(); check("t1_pc0", pc_o, 32'h0);
    tick(); check("t1_pc1", pc_o, 32'h4);
    tick(); check("t1_pc2", pc_o, 32'h8);
    check("t1_valid", valid_o, 1'b1);
    check("t1_next_addr", imem_addr_o, 32'hC);

    // Two wait cycles on the request at 0x4.
    do_reset(32'h0);
    tick();
    tick();
    mem_wait = 2;
    tick(); check("t2_wait1_addr", imem_addr_o, 32'h4); check("t2_wait1_valid", valid_o, 1'b0);
    tick(); check("t2_wait2_addr", imem_addr_o, 32'h4); check("t2_wait2_inst", inst_o, NOP);
    tick(); check("t2_ack_pc", pc_o, 32'h4); check("t2_ack_addr", imem_addr_o, 32'h8);

    // Stall for 3 cycles starting when 0x8 is acked.
    mem_wait = 0;
    stall_i  = 1'b1;
    tick(); check("t3_hold_pc", pc_o, 32'h4); check("t3_hold_req", imem_req_o, 1'b0);
    tick();
    tick(); check("t3_hold3_pc", pc_o, 32'h4); check("t3_hold3_inst", inst_o, mem_fn(32'h4));
    stall_i = 1'b0;
    tick();
    check("t3_release_pc", pc_o, 32'h8);
    check("t3_release_inst", inst_o, mem_fn(32'h8));
    check("t3_next_addr", imem_addr_o, 32'hC);
    check("t3_next_req", imem_req_o, 1'b1);

    // Flush with the request at 0x10 outstanding.
    tick(); check("t4_pc_c", pc_o, 32'hC);
    mem_wait  = 1000;
    flush_i   = 1'b1;
    flush_tgt = 32'h40;
    tick();
    check("t4_flush_valid", valid_o, 1'b0);
    check("t4_drain_req", imem_req_o, 1'b1);
    check("t4_drain_addr", imem_addr_o, 32'h10);
    flush_i = 1'b0;
    tick(); check("t4_drain_addr2", imem_addr_o, 32'h10);
    mem_wait = 0;
    tick(); check("t4_issue_req", imem_req_o, 1'b0); check("t4_dropped_valid", valid_o, 1'b0);
    tick(); check("t4_target_addr", imem_addr_o, 32'h40);
    tick(); check("t4_target_pc", pc_o, 32'h40);

    // Flush and stall together while holding 0x44.
    stall_i = 1'b1;
    tick(); check("t5_hold_req", imem_req_o, 1'b0);
    flush_i   = 1'b1;
    flush_tgt = 32'h80;
    tick(); check("t5_flush_valid", valid_o, 1'b0); check("t5_flush_inst", inst_o, NOP);
    stall_i = 1'b0;
    flush_i = 1'b0;
    tick(); check("t5_target_addr", imem_addr_o, 32'h80);
    tick(); check("t5_target_pc", pc_o, 32'h80);

    // Address wrap at the top of the address space.
    flush_i   = 1'b1;
    flush_tgt = 32'hFFFF_FFFC;
    tick(); check("t6_issue_req", imem_req_o, 1'b0);
    flush_i = 1'b0;
    tick(); check("t6_top_addr", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    check("t6_top_pc", pc_o, 32'hFFFF_FFFC);
    check("t6_wrap_pc4", pc_plus4_o, 32'h0);
    check("t6_wrap_addr", imem_addr_o, 32'h0);
    tick(); check("t6_wrapped_pc", pc_o, 32'h0);

    // Asynchronous reset in the middle of FETCH, between clock edges.
    mem_wait = 1000;
    #3;
    imem_ack_i = 1'b0;
    rst_i      = 1'b1;
    #1;
    check("t7_req", imem_req_o, 1'b0);
    check("t7_addr", imem_addr_o, 32'h0);
    check("t7_inst", inst_o, NOP);
    check("t7_pc", pc_o, 32'h0);
    check("t7_pc4", pc_plus4_o, 32'h0);
    check("t7_valid", valid_o, 1'b0);
    check("t7_pc_write", pc_write_o, 1'b0);

    // Randomised run: wait states, stalls, flushes, stray acks, dirty pc_i[1:0].
    do_reset($urandom & 32'hFFFF_FFFC);
    rnd_mode = 1'b1;
    mem_wait = 0;
    d0       = delivered;
    for (int i = 0; i < 2000; i++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      if (imem_req_o && $urandom_range(0, 19) == 0) begin
        flush_i   = 1'b1;
        flush_tgt = $urandom & 32'hFFFF_FFFC;
      end else begin
        flush_i = 1'b0;
      end
      tick();
    end
    stall_i = 1'b0;
    flush_i = 1'b0;
    tick();
    tick();
    check("random_progress", (delivered - d0) >= 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
